// File: rtl/c_mult_ctrl.sv
// Complex-multiply sequencer: time-shares one multiplier and one add_sub unit over
// six states to form re = ar*br - ai*bi and im = ar*bi + ai*br.
module c_mult_ctrl #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2**N-1:0]   ar,
    input  logic [2**N-1:0]   ai,
    input  logic [2**N-1:0]   br,
    input  logic [2**N-1:0]   bi,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   re,
    output logic [2**N-1:0]   im,
    output logic [2**N-1:0]   mul_a,
    output logic [2**N-1:0]   mul_b,
    input  logic [2**N-1:0]   mul_p,
    output logic              as_add,
    output logic [2**N-1:0]   as_a,
    output logic [2**N-1:0]   as_b,
    input  logic [2**N-1:0]   as_result
);
    localparam int W = 2**N;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RR   = 3'd1,
        II   = 3'd2,
        SUB  = 3'd3,
        RI   = 3'd4,
        IR   = 3'd5,
        ADD  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
    logic [W-1:0]   p0_q, p0_d, p1_q, p1_d;
    logic [W-1:0]   re_q, re_d, im_q, im_d;
    logic           done_q, done_d;

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        br_d    = br_q;
        bi_d    = bi_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        re_d    = re_q;
        im_d    = im_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RR;
                    ar_d    = ar;
                    ai_d    = ai;
                    br_d    = br;
                    bi_d    = bi;
                end
            end
            RR:  begin p0_d = mul_p;     state_d = II;  end
            II:  begin p1_d = mul_p;     state_d = SUB; end
            SUB: begin re_d = as_result; state_d = RI;  end
            RI:  begin p0_d = mul_p;     state_d = IR;  end
            IR:  begin p1_d = mul_p;     state_d = ADD; end
            ADD: begin
                im_d    = as_result;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shared-unit operands are a pure decode of state, so idle units see zeros.
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        as_add = 1'b0;
        as_a   = '0;
        as_b   = '0;
        case (state_q)
            RR:  begin mul_a = ar_q; mul_b = br_q; end
            II:  begin mul_a = ai_q; mul_b = bi_q; end
            RI:  begin mul_a = ar_q; mul_b = bi_q; end
            IR:  begin mul_a = ai_q; mul_b = br_q; end
            SUB: begin as_a = p0_q; as_b = p1_q; end
            ADD: begin as_add = 1'b1; as_a = p0_q; as_b = p1_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ar_q    <= '0;
            ai_q    <= '0;
            br_q    <= '0;
            bi_q    <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            re_q    <= '0;
            im_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            re_q    <= re_d;
            im_q    <= im_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign re   = re_q;
    assign im   = im_q;
endmodule
